// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and width helper for the parametrised synchronous FIFO
package sync_fifo_pkg;

  localparam int SYNC_FIFO_DW_DEF    = 8;
  localparam int SYNC_FIFO_DEPTH_DEF = 16;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DW x DEPTH register array, one write port, one registered read port
module sync_fifo_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register loads only on an accepted read, otherwise holds the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_pw.sv
// rtl/sync_fifo_pw.sv - parametrised synchronous FIFO top; sticky errors built only with SYNC_FIFO_ERR_EN
module sync_fifo_pw
  import sync_fifo_pkg::*;
#(
  parameter int DW     = SYNC_FIFO_DW_DEF,
  parameter int DEPTH  = SYNC_FIFO_DEPTH_DEF,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [DW-1:0]             din,
  input  logic                      re,
  output logic [DW-1:0]             dout,
  output logic                      rvalid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  // Reject illegal configurations at elaboration.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (DW < 1)) begin : g_bad_depth
    $fatal(1, "sync_fifo_pw: DEPTH must be a power of two >= 4 and DW >= 1");
  end
  if ((AE_LVL < 0) || (AE_LVL >= AF_LVL) || (AF_LVL > DEPTH)) begin : g_bad_lvl
    $fatal(1, "sync_fifo_pw: need 0 <= AE_LVL < AF_LVL <= DEPTH");
  end

  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, af_q, ae_q, rvalid_q;
  logic          wr_ok, rd_ok;

  // Acceptance looks only at registered flags, so a full FIFO can still swap a read for a rejected write.
  assign wr_ok = we && !full_q;
  assign rd_ok = re && !empty_q;

  // Next occupancy drives every status flag so flags line up with count.
  always_comb begin
    count_d = count_q + {{(CW-1){1'b0}}, wr_ok} - {{(CW-1){1'b0}}, rd_ok};
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= CW'(AF_LVL));
      ae_q     <= (count_d <= CW'(AE_LVL));
      rvalid_q <= rd_ok;
    end
  end

  sync_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (din),
    .rd_en_i (rd_ok),
    .raddr_i (rptr_q),
    .rdata_o (dout)
  );

  assign rvalid       = rvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, udf_q, ovf_d, udf_d;

  // A new error event in the same cycle as err_clr must survive the clear.
  always_comb begin
    ovf_d = (err_clr ? 1'b0 : ovf_q) | (we && full_q);
    udf_d = (err_clr ? 1'b0 : udf_q) | (re && empty_q);
  end

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_pw.sv
// tb/tb_sync_fifo_pw.sv - self-checking bench for sync_fifo_pw against a queue-based reference model
module tb_sync_fifo_pw;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0, re = 1'b0, err_clr = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int passed = 0;
  int total  = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_rvalid, m_ovf, m_udf;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic [4:0] e_count;
    logic [7:0] e_dout;
    logic       e_rvalid;
    logic       e_empty;
  } vec_t;
  vec_t tbl[8];

  sync_fifo_pw #(.DW(DW), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (we),
    .din          (din),
    .re           (re),
    .dout         (dout),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_rvalid = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_model();
    logic exp_o, exp_u;
`ifdef SYNC_FIFO_ERR_EN
    exp_o = m_ovf;
    exp_u = m_udf;
`else
    exp_o = 1'b0;
    exp_u = 1'b0;
`endif
    chk("count", 32'(count), q.size());
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("overflow", 32'(overflow), 32'(exp_o));
    chk("underflow", 32'(underflow), 32'(exp_u));
  endtask

  // One clock: drive inputs, advance the model by the FIFO's rules, then compare.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit mfull, mempty;
    we = w; din = d; re = r; err_clr = c;
    mfull  = (q.size() == DEPTH);
    mempty = (q.size() == 0);
    @(posedge clk);
    if (r && !mempty) begin
      m_dout = q.pop_front();
      m_rvalid = 1'b1;
    end else begin
      m_rvalid = 1'b0;
    end
    if (w && !mfull) q.push_back(d);
    m_ovf = (c ? 1'b0 : m_ovf) | (w && mfull);
    m_udf = (c ? 1'b0 : m_udf) | (r && mempty);
    #1;
    we = 1'b0; re = 1'b0; err_clr = 1'b0;
    check_model();
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 5'd1, 8'h11, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h33, 1'b1, 5'd1, 8'h22, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 5'd1, 8'h22, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h33, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 8'h55, 1'b1, 5'd1, 8'h33, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h55, 1'b1, 1'b1};

    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_errors", 32'({overflow, underflow}), 0);
    check_model();

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
      chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].e_rvalid));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
    end

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) chk("af_at_13", 32'(almost_full), 0);
      if (i == 13) chk("af_at_14", 32'(almost_full), 1);
    end
    chk("full_after_16", 32'(full), 1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("seq_dout", 32'(dout), i);
      chk("seq_rvalid", 32'(rvalid), 1);
      if (i == 0) chk("full_drop", 32'(full), 0);
    end
    chk("empty_after_drain", 32'(empty), 1);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("ovf_dout", 32'(dout), 0);
    chk("ovf_count", 32'(count), 15);
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf_flag", 32'(overflow), 1);
`endif
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ovf_drain", 32'(dout), i);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("steady_count", 32'(count), 8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
`ifdef SYNC_FIFO_ERR_EN
    chk("udf_set_wins", 32'(underflow), 1);
`endif

    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_rvalid", 32'(rvalid), 0);
    model_reset();
    #2 rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_dout", 32'(dout), 32'h3C);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_pw.md
# sync_fifo_pw

Parametrised synchronous FIFO and the successor to the team's fixed 8×16 FIFO. It is a circular buffer with independent read/write pointers, an occupancy count, programmable almost-full/almost-empty thresholds, and defined simultaneous read/write behaviour. It sits between single-clock producer/consumer blocks as the standard buffering primitive.

## Interface
Parameters:
- DW, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LVL, DEPTH-2, almost_full asserts when count ≥ AF_LVL
- AE_LVL, 2, almost_empty asserts when count ≤ AE_LVL

Ports. One clock; reset is asynchronous and active-low; ports `clk` and `rst_n`.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write request
- din  in  DW  write data
- re  in  1  read request
- dout  out  DW  read data, registered
- rvalid  out  1  dout was loaded by a read accepted on the previous edge
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LVL
- almost_empty  out  1  count ≤ AE_LVL
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected
- err_clr  in  1  clears overflow/underflow

## Operation
- Acceptance uses registered flags only:
  - wr_ok = we && !full
  - rd_ok = re && !empty
- On wr_ok: mem[wptr] ← din, and wptr increments. Pointers are $clog2(DEPTH) bits and wrap DEPTH-1→0 naturally.
- On rd_ok: dout ← mem[rptr], rptr increments, and rvalid=1 on the following cycle. Otherwise rvalid=0 and dout holds its last value. No Z is ever driven.
- count_next = count + wr_ok − rd_ok:
  - both accepted: count unchanged, both pointers advance.
  - full with we&&re: read accepted, write rejected, overflow set.
  - empty with we&&re: write accepted, read rejected, underflow set.
- All flags are registered and computed from count_next. They are valid the cycle after the causing edge.
- Sticky errors: overflow sets on we&&full; underflow sets on re&&empty. err_clr clears both. If a set and err_clr occur in the same cycle, set wins.
- Reset values:
  - wptr=rptr=0, count=0, dout=0
  - rvalid=0, full=0, empty=1, almost_full=0, almost_empty=1
  - overflow=underflow=0
  - Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately (asynchronously). The first accepted write after deassertion lands at entry 0.

## Timing
- Write→read availability: a write at edge N clears empty after N. A read can be accepted at edge N+1; dout/rvalid are valid after N+1.
- Read latency: 1 cycle from the accepting edge to dout.
- full asserts the cycle after the DEPTH-th accepted write. It deasserts the cycle after the first accepted read.
- Back-to-back reads at 1 per cycle are sustained; rvalid stays high continuously.
- Parameter legality is checked at elaboration: DEPTH power of two, 0 ≤ AE_LVL < AF_LVL ≤ DEPTH. Violations are a fatal elaboration error.

## Configuration
- Macro: `SYNC_FIFO_ERR_EN`.
- Defined: overflow/underflow sticky registers and err_clr behave as above.
- Undefined: overflow and underflow are tied to 0, err_clr is ignored, and no error registers are built. All other behaviour is identical.

## Structure
- Package `sync_fifo_pkg`:
  - default constants SYNC_FIFO_DW_DEF=8 and SYNC_FIFO_DEPTH_DEF=16
  - function `cnt_w(depth)` returning $clog2(depth)+1
- Sub-module `sync_fifo_ram`: DW×DEPTH register array, one write port, one synchronous read port with read enable. The top holds pointers, count, flags and errors.

## Test plan
All scenarios use DW=8, DEPTH=16, AF_LVL=14, AE_LVL=2 unless stated.
- Reset then idle → empty=1, almost_empty=1, count=0, dout=0x00, rvalid=0, errors=0.
- Write 0x00..0x0F, then read 16 → dout sequence 0x00..0x0F with rvalid each cycle. full=1 after the 16th write; almost_full from count 14; empty=1 after the last read.
- Fill to 16, then assert we=1 din=0xAA with re=1 → dout=0x00, count stays 15 after, overflow=1. 0xAA is never read back.
- Empty FIFO, we=1 din=0x55 and re=1 together → count=1, underflow=1, rvalid=0. The next read returns 0x55.
- Steady state count=8, we&&re for 40 cycles (pointers wrap) → count stays 8, data emerges in order. err_clr with a simultaneous re on empty leaves underflow=1.
- Assert rst_n=0 mid-stream at count=9 → immediately count=0, empty=1, rvalid=0. A subsequent write/read of 0x3C returns 0x3C. Rebuilt without `SYNC_FIFO_ERR_EN`, overflow/underflow stay 0 in all scenarios.
